// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and fetch queue entry type for the fetch stage
package cpu_pkg;

  localparam int AW          = 7;
  localparam int IW          = 16;
  localparam int FETCH_DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry in-order instruction queue with push, pop and flush
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  localparam logic [1:0] FULL_COUNT = 2'(FETCH_DEPTH);

  fetch_entry_t mem_q [FETCH_DEPTH];
  fetch_entry_t mem_d [FETCH_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  // Next-state: flush empties the queue and beats any same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & (count_q != 2'd0);
    do_push  = push_i & ((count_q != FULL_COUNT) | do_pop);
    // With two slots the tail is the head slot offset by count modulo 2.
    wr_ptr   = rd_ptr_q ^ count_q[0];
    if (flush_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr] = push_entry_i;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // State register; reset also zeroes storage so the head outputs read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: issue control, wrong-path drop, decoder handshake
module fetch_unit
  import cpu_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] pc_i,
  input  logic          branch_en_i,
  output logic          pc_stall_o,
  output logic [AW-1:0] imem_addr_o,
  output logic          imem_rd_o,
  input  logic [IW-1:0] imem_data_i,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
  output logic          instr_valid_o,
  input  logic          instr_ready_i
);

  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;

  logic [1:0]    q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  push_entry;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    occupancy;

  // A read may issue only if its response is guaranteed a free slot next cycle.
  always_comb begin
    pop        = instr_valid_o & instr_ready_i;
    occupancy  = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = ~rst_i & ~branch_en_i & (occupancy <= 3'd1);
    push       = inflight_q & ~drop_q;
    push_entry = '{pc: inflight_pc_q, instr: imem_data_i};
  end

  // Read tracking: remember what is in flight and whether a branch orphaned it.
  always_comb begin
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_i : inflight_pc_q;
    drop_d        = branch_en_i & inflight_q;
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q    <= 1'b0;
      drop_q        <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      drop_q        <= drop_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (branch_en_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (q_head),
    .count_o      (q_count)
  );

  assign imem_addr_o   = pc_i;
  assign imem_rd_o     = issue;
  assign pc_stall_o    = ~rst_i & ~branch_en_i & ~issue;
  assign instr_valid_o = (q_count != 2'd0) & ~rst_i;
  assign instr_o       = q_head.instr;
  assign instr_pc_o    = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

  logic        clk;
  logic        rst_i;
  logic [6:0]  pc_i;
  logic        branch_en_i;
  logic        pc_stall_o;
  logic [6:0]  imem_addr_o;
  logic        imem_rd_o;
  logic [15:0] imem_data_i;
  logic [15:0] instr_o;
  logic [6:0]  instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;

  int checks;
  int failures;

  logic [15:0] mem_arr [128];

  // reference model: queue of {pc, instr}, one pending response, drop flag
  logic [22:0] m_q [$];
  bit          p_valid;
  bit          m_drop;
  logic [22:0] p_entry;
  logic [22:0] dl [$];
  logic [6:0]  pc_cur;

  bit obs_valid, obs_rd, obs_stall;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .branch_en_i   (branch_en_i),
    .pc_stall_o    (pc_stall_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rd_o     (imem_rd_o),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction memory, 1-cycle latency
  always @(posedge clk) begin
    if (imem_rd_o) imem_data_i <= mem_arr[imem_addr_o];
  end

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < 128; a++) begin
      mem_arr[a] = rnd ? 16'($urandom) : 16'hA000 + 16'(a);
    end
  endtask

  // one clock: drive, compare against model, advance model and PC source
  task automatic cycle(input bit r, input bit b, input bit rdy, input logic [6:0] tgt);
    bit e_valid, e_pop, e_issue, e_stall, push_ok;
    int occ;
    rst_i = r; branch_en_i = b; instr_ready_i = rdy; pc_i = pc_cur;
    #1;
    e_valid = !r && (m_q.size() != 0);
    e_pop   = e_valid && rdy;
    occ     = m_q.size() + int'(p_valid) - int'(e_pop);
    e_issue = !r && !b && (occ <= 1);
    e_stall = !r && !b && !e_issue;
    obs_valid = instr_valid_o; obs_rd = imem_rd_o; obs_stall = pc_stall_o;
    checks++;
    if (instr_valid_o !== e_valid) begin
      failures++; $display("FAIL valid got=%b exp=%b", instr_valid_o, e_valid);
    end
    if (e_valid) begin
      checks++;
      if ({instr_pc_o, instr_o} !== m_q[0]) begin
        failures++; $display("FAIL head got=%h/%h exp=%h/%h", instr_pc_o, instr_o, m_q[0][22:16], m_q[0][15:0]);
      end
    end
    checks++;
    if (imem_rd_o !== e_issue) begin
      failures++; $display("FAIL imem_rd got=%b exp=%b", imem_rd_o, e_issue);
    end
    checks++;
    if (pc_stall_o !== e_stall) begin
      failures++; $display("FAIL pc_stall got=%b exp=%b", pc_stall_o, e_stall);
    end
    if (e_issue) begin
      checks++;
      if (imem_addr_o !== pc_cur) begin
        failures++; $display("FAIL imem_addr got=%0d exp=%0d", imem_addr_o, pc_cur);
      end
    end
    @(posedge clk);
    if (r) begin
      m_q.delete(); p_valid = 0; m_drop = 0;
    end else begin
      if (e_pop) dl.push_back(m_q[0]);
      push_ok = p_valid && !m_drop && !b;
      if (b) m_q.delete();
      else begin
        if (e_pop) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(p_entry);
      end
      checks++;
      if (m_q.size() > 2) begin
        failures++; $display("FAIL overflow got=%0d exp<=2", m_q.size());
      end
      m_drop  = b && p_valid;
      p_valid = e_issue;
      if (e_issue) p_entry = {pc_cur, mem_arr[pc_cur]};
    end
    pc_cur = r ? 7'd0 : b ? tgt : e_stall ? pc_cur : pc_cur + 7'd1;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [6:0] start_pc);
    cycle(1, 0, 0, 0);
    pc_cur = start_pc;
    dl.delete();
  endtask

  task automatic test_reset();
    cycle(1, 0, 1, 0);
    checks++;
    if (instr_valid_o !== 1'b0 || instr_o !== 16'h0 || instr_pc_o !== 7'h0) begin
      failures++; $display("FAIL reset_outputs got=%b/%h/%h exp=0/0/0", instr_valid_o, instr_o, instr_pc_o);
    end
    checks++;
    if (obs_rd !== 1'b0 || obs_stall !== 1'b0) begin
      failures++; $display("FAIL reset_rd_stall got=%b/%b exp=0/0", obs_rd, obs_stall);
    end
  endtask

  task automatic test_stream();
    int first_valid;
    bit any_stall;
    logic [22:0] e;
    do_reset(0);
    first_valid = -1; any_stall = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 1, 0);
      if (obs_valid && first_valid < 0) first_valid = i;
      any_stall |= obs_stall;
    end
    checks++;
    if (first_valid != 2) begin
      failures++; $display("FAIL stream_latency got=%0d exp=2", first_valid);
    end
    checks++;
    if (any_stall) begin
      failures++; $display("FAIL stream_stall got=1 exp=0");
    end
    for (int k = 0; k < 4; k++) begin
      e = {7'(k), 16'hA000 + 16'(k)};
      checks++;
      if (dl.size() <= k || dl[k] !== e) begin
        failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", k, (dl.size() > k) ? dl[k] : 23'h0, e);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(5);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    checks++;
    if (obs_stall !== 1'b1 || obs_rd !== 1'b0 || instr_pc_o !== 7'd5) begin
      failures++; $display("FAIL bp_hold got=%b/%b/%0d exp=1/0/5", obs_stall, obs_rd, instr_pc_o);
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dl.size() <= k || dl[k][22:16] !== 7'(5 + k)) begin
        failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", k, (dl.size() > k) ? dl[k][22:16] : 7'h7f, 5 + k);
      end
    end
  endtask

  task automatic test_branch_flush();
    do_reset(10);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 40);
    checks++;
    if (obs_rd !== 1'b0 || obs_stall !== 1'b0) begin
      failures++; $display("FAIL br_no_read got=%b/%b exp=0/0", obs_rd, obs_stall);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      failures++; $display("FAIL br_valid_after got=%b exp=0", obs_valid);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    checks++;
    if (dl.size() < 2 || dl[0][22:16] !== 7'd10 || dl[1][22:16] !== 7'd40) begin
      failures++; $display("FAIL br_order got=%0d exp>=2 entries 10,40", dl.size());
    end
  endtask

  task automatic test_flush_full();
    do_reset(20);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 60);
    checks++;
    if (obs_valid !== 1'b1) begin
      failures++; $display("FAIL ff_full got=%b exp=1", obs_valid);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      failures++; $display("FAIL ff_empty got=%b exp=0", obs_valid);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    checks++;
    if (dl.size() < 2 || dl[0][22:16] !== 7'd20 || dl[1][22:16] !== 7'd60) begin
      failures++; $display("FAIL ff_order got=%0d exp>=2 entries 20,60", dl.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset(30);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0);
    checks++;
    if (obs_valid !== 1'b0 || obs_rd !== 1'b0 || obs_stall !== 1'b0) begin
      failures++; $display("FAIL rst_mid got=%b/%b/%b exp=0/0/0", obs_valid, obs_rd, obs_stall);
    end
    dl.delete();
    cycle(0, 0, 1, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_after got=%b exp=0", obs_valid);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    checks++;
    if (dl.size() < 1 || dl[0] !== {7'd0, 16'hA000}) begin
      failures++; $display("FAIL rst_mid_first got=%0d exp=1+ entries starting pc0", dl.size());
    end
  endtask

  task automatic test_wrap();
    logic [6:0] p;
    do_reset(126);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      p = 7'(126 + k);
      checks++;
      if (dl.size() <= k || dl[k] !== {p, 16'hA000 + 16'(p)}) begin
        failures++; $display("FAIL wrap idx=%0d got=%h exp=%h", k, (dl.size() > k) ? dl[k] : 23'h0, {p, 16'hA000 + 16'(p)});
      end
    end
  endtask

  task automatic test_random();
    bit r, b, rdy;
    fill_mem(1);
    do_reset(7'($urandom));
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom % 200) == 0;
      b   = ($urandom % 8) == 0;
      rdy = ($urandom % 3) != 0;
      cycle(r, b, rdy, 7'($urandom));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_i = 1; branch_en_i = 0; instr_ready_i = 0; pc_i = 0; imem_data_i = 0;
    p_valid = 0; m_drop = 0; p_entry = 0; pc_cur = 0;
    fill_mem(0);
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_flush();
    test_flush_full();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
